// File: rtl/data_bus_memory.sv
// data_bus_memory
// Word-addressed data RAM on the CPU data bus. Accesses are decoded against a
// fixed address window; writes complete in one cycle (WACK pulse), reads return
// through a RD_LAT-deep pipeline (RVALID pulse). Out-of-window or misaligned
// accesses return MISS_DATA on reads, leave the RAM untouched, and latch the
// first offending address in a sticky error record.
module data_bus_memory #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH_LOG2 = 10,
  parameter logic [31:0]       BASE_ADDR  = 32'h0000_1000,
  parameter int                RD_LAT     = 2,
  parameter logic [DATA_W-1:0] MISS_DATA  = 32'hDEAD_BEEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       ADDR,
  input  logic [DATA_W-1:0] Data_BUS_WRITE,
  input  logic              CS,
  input  logic              WR,
  input  logic              ERR_CLR,
  output logic [DATA_W-1:0] Data_BUS_READ,
  output logic              RVALID,
  output logic              WACK,
  output logic              ERR,
  output logic [31:0]       ERR_ADDR
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH) << 2;

  // A read latency outside 1..4 is a configuration error, caught at elaboration.
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("data_bus_memory: RD_LAT must be in 1..4");
  end

  // Address decode. The lower-bound test catches subtraction underflow; the
  // upper bound is compared at 33 bits so a window touching 2**32 still works.
  logic [31:0]           w_off;
  logic                  w_hit;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_err;
  logic [DATA_W-1:0]     w_rd_val;

  logic [DATA_W-1:0] r_mem [DEPTH];

  assign w_off    = ADDR - BASE_ADDR;
  assign w_hit    = (ADDR >= BASE_ADDR) && ({1'b0, w_off} < WIN_BYTES) && (ADDR[1:0] == 2'b00);
  assign w_idx    = w_off[DEPTH_LOG2+1:2];
  assign w_rd     = CS & ~WR;
  assign w_wr     = CS & WR;
  assign w_err    = CS & ~w_hit;
  // Reads and writes never share an edge, so a read one edge after a write
  // already sees the new word: write-first falls out of this ordering.
  assign w_rd_val = w_hit ? r_mem[w_idx] : MISS_DATA;

  // RAM array: write on a hit.
  // NOTE: the RAM array has no reset branch so it maps onto block RAM; only control and output flops are reset.
  always_ff @(posedge CLK) begin
    if (w_wr && w_hit) begin
      r_mem[w_idx] <= Data_BUS_WRITE;
    end
  end

  // Read pipeline: stage 0 captures at the access edge, stage RD_LAT is the
  // output register. The last stage loads only on a valid result so the bus
  // holds its previous value between results.
  logic              r_pvld  [RD_LAT+1];
  logic [DATA_W-1:0] r_pdata [RD_LAT+1];

  // Shift read results toward the output; reset flushes anything in flight.
  // NOTE: sequential state uses non-blocking (<=) so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        r_pvld[i]  <= 1'b0;
        r_pdata[i] <= '0;
      end
    end else begin
      r_pvld[0]  <= w_rd;
      r_pdata[0] <= w_rd_val;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_pvld[i] <= r_pvld[i-1];
        if (i < RD_LAT || r_pvld[i-1]) begin
          r_pdata[i] <= r_pdata[i-1];
        end
      end
    end
  end

  assign Data_BUS_READ = r_pdata[RD_LAT];
  assign RVALID        = r_pvld[RD_LAT];

  // Write acknowledge: one-cycle pulse after every write access, hit or miss.
  logic r_wack;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wack <= 1'b0;
    end else begin
      r_wack <= w_wr;
    end
  end

  assign WACK = r_wack;

  // Sticky error record: first error since the last clear wins, but a new
  // error arriving together with a clear replaces the cleared record.
  logic        r_err;
  logic [31:0] r_err_addr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_err) begin
      r_err <= 1'b1;
      if (!r_err || ERR_CLR) begin
        r_err_addr <= ADDR;
      end
    end else if (ERR_CLR) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end
  end

  assign ERR      = r_err;
  assign ERR_ADDR = r_err_addr;

endmodule

// File: tb/tb_data_bus_memory.sv
// tb_data_bus_memory
// Directed bench for data_bus_memory. Three instances share one stimulus
// stream (RD_LAT = 2, 1, 4); most checks use the RD_LAT=2 instance, the
// back-to-back read burst checks all three.
module tb_data_bus_memory;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        cs;
  logic        wr;
  logic        err_clr;

  logic [31:0] rdata   [3];
  logic        rvalid  [3];
  logic        wack    [3];
  logic        err     [3];
  logic [31:0] err_addr[3];

  int n_total = 0;
  int n_bad   = 0;

  // Latency of instance j; index 0 is the main RD_LAT=2 instance.
  int lat [3] = '{2, 1, 4};

  data_bus_memory #(.RD_LAT(2)) u_dut (
    .CLK(clk), .RST(rst), .ADDR(addr), .Data_BUS_WRITE(wdata), .CS(cs), .WR(wr),
    .ERR_CLR(err_clr), .Data_BUS_READ(rdata[0]), .RVALID(rvalid[0]), .WACK(wack[0]),
    .ERR(err[0]), .ERR_ADDR(err_addr[0])
  );

  data_bus_memory #(.RD_LAT(1)) u_dut_l1 (
    .CLK(clk), .RST(rst), .ADDR(addr), .Data_BUS_WRITE(wdata), .CS(cs), .WR(wr),
    .ERR_CLR(err_clr), .Data_BUS_READ(rdata[1]), .RVALID(rvalid[1]), .WACK(wack[1]),
    .ERR(err[1]), .ERR_ADDR(err_addr[1])
  );

  data_bus_memory #(.RD_LAT(4)) u_dut_l4 (
    .CLK(clk), .RST(rst), .ADDR(addr), .Data_BUS_WRITE(wdata), .CS(cs), .WR(wr),
    .ERR_CLR(err_clr), .Data_BUS_READ(rdata[2]), .RVALID(rvalid[2]), .WACK(wack[2]),
    .ERR(err[2]), .ERR_ADDR(err_addr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle; outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    cs    = c;
    wr    = w;
    addr  = a;
    wdata = d;
  endtask

  initial begin
    logic exp_v;

    rst = 1'b1; cs = 1'b0; wr = 1'b0; addr = '0; wdata = '0; err_clr = 1'b0;
    #2 rst = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_rdata",    rdata[0],    32'h0);
    check("rst_rvalid",   rvalid[0],   1'b0);
    check("rst_wack",     wack[0],     1'b0);
    check("rst_err",      err[0],      1'b0);
    check("rst_err_addr", err_addr[0], 32'h0);
    rst = 1'b1;
    tick();

    // Test 1: single write then read at the base address
    drive(1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_0001);
    tick();
    check("t1_wack",       wack[0],   1'b1);
    check("t1_rvalid_w",   rvalid[0], 1'b0);
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    tick();
    check("t1_wack_off",   wack[0],   1'b0);
    check("t1_rvalid_t0",  rvalid[0], 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("t1_rvalid_t1",  rvalid[0], 1'b0);
    tick();
    check("t1_rvalid_t2",  rvalid[0], 1'b1);
    check("t1_rdata",      rdata[0],  32'hCAFE_0001);
    tick();
    check("t1_rvalid_end", rvalid[0], 1'b0);
    check("t1_rdata_hold", rdata[0],  32'hCAFE_0001);

    // Test 2 / 6: four writes, then a burst of four reads checked on all latencies
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h0000_1004 + 32'(4 * i), 32'(i + 1));
      tick();
      check("t2_wack", wack[0], 1'b1);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int k = 0; k < 9; k++) begin
      if (k < 4) drive(1'b1, 1'b0, 32'h0000_1004 + 32'(4 * k), 32'h0);
      else       drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      for (int j = 0; j < 3; j++) begin
        exp_v = (k >= lat[j]) && (k <= lat[j] + 3);
        check($sformatf("t2_rvalid_lat%0d_k%0d", lat[j], k), rvalid[j], exp_v);
        if (exp_v)
          check($sformatf("t2_rdata_lat%0d_k%0d", lat[j], k), rdata[j], 32'(k - lat[j] + 1));
        else if (k > lat[j] + 3)
          check($sformatf("t2_hold_lat%0d_k%0d", lat[j], k), rdata[j], 32'd4);
      end
    end

    // Test 3: write-first plus WACK/RVALID overlap
    drive(1'b1, 1'b0, 32'h0000_1004, 32'h0);       // read (value 1)
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_1008, 32'h0000_0055); // write while read retires
    tick();
    check("t3_wack",      wack[0],   1'b1);
    check("t3_rvalid",    rvalid[0], 1'b1);
    check("t3_rdata_old", rdata[0],  32'h1);
    drive(1'b1, 1'b0, 32'h0000_1008, 32'h0);       // read one edge after write
    tick();
    check("t3_wack_off",  wack[0],   1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("t3_rvalid_new", rvalid[0], 1'b1);
    check("t3_rdata_new",  rdata[0],  32'h55);

    // Test 4: misses and the error record
    drive(1'b1, 1'b0, 32'h0000_0FFC, 32'h0);
    tick();
    check("t4_err",       err[0],      1'b1);
    check("t4_err_addr",  err_addr[0], 32'h0000_0FFC);
    drive(1'b1, 1'b1, 32'h0000_1002, 32'h0000_0077);
    tick();
    check("t4_miss_wack", wack[0],     1'b1);
    check("t4_err_keep",  err_addr[0], 32'h0000_0FFC);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("t4_miss_rvalid", rvalid[0], 1'b1);
    check("t4_miss_rdata",  rdata[0],  32'hDEAD_BEEF);
    err_clr = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_2000, 32'h0);
    tick();
    check("t4_clr_new_err",  err[0],      1'b1);
    check("t4_clr_new_addr", err_addr[0], 32'h0000_2000);
    err_clr = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("t4_top_rdata", rdata[0], 32'hDEAD_BEEF);
    err_clr = 1'b1;
    tick();
    check("t4_clr_err",  err[0],      1'b0);
    check("t4_clr_addr", err_addr[0], 32'h0);
    err_clr = 1'b0;
    drive(1'b1, 1'b1, 32'h0000_1FFC, 32'h0000_B0B0);
    tick();
    drive(1'b1, 1'b0, 32'h0000_1FFC, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("t4_last_word",   rdata[0], 32'h0000_B0B0);
    check("t4_last_no_err", err[0],   1'b0);
    drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);       // underflowing offset
    tick();
    check("t4_under_err_addr", err_addr[0], 32'h0000_0004);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Test 5: reset in the middle of two reads
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0000_1004, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check("t5_rdata",    rdata[0],    32'h0);
    check("t5_rvalid",   rvalid[0],   1'b0);
    check("t5_err",      err[0],      1'b0);
    check("t5_err_addr", err_addr[0], 32'h0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t5_no_rvalid_%0d", k), rvalid[0], 1'b0);
      check($sformatf("t5_no_wack_%0d", k),   wack[0],   1'b0);
    end
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("t5_ram_rvalid", rvalid[0], 1'b1);
    check("t5_ram_intact", rdata[0],  32'hCAFE_0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
